control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle instruction sequencer that sits directly upstream of the 4-entry register file and its ALU. It accepts instruction words from the fetch stage over a valid/ready handshake and decodes them. It then drives the register-file read-enables and addresses, the ALU operation, the write-back select and the write-enable, so that every instruction retires through the register file's registered read ports.

## Interface
Parameters:
- REGISTER_LEN, 10, datapath and instruction word width (minimum 10)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- INSTR  in  REGISTER_LEN  instruction or immediate word from fetch
- IVALID  in  1  INSTR valid
- IREADY  out  1  controller accepts INSTR; a transfer occurs when IVALID && IREADY at a rising edge
- RAE / RAA  out  1 / 2  register-file port A read enable / address
- RBE / RBA  out  1 / 2  register-file port B read enable / address
- WE / WA  out  1 / 2  register-file write enable / address
- ALUOP  out  3  000 PASSB, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 NOTA
- RFSEL  out  1  write-back mux select: 0 = ALU result, 1 = IMM
- IMM  out  REGISTER_LEN  latched immediate word
- DONE  out  1  one-cycle pulse on instruction retire
- ILLEGAL  out  1  one-cycle pulse, coincident with DONE, for an undefined opcode

## Operation
- Instruction fields:
  - opcode = INSTR[9:6], Rx = INSTR[5:4], Ry = INSTR[3:2]
  - INSTR[1:0] and bits above 9 are ignored
- Opcodes:
  - 0000 NOP
  - 0001 LOADI Rx: the next accepted word is the immediate
  - 0010 MOV Rx<=Ry
  - 0011 ADD, 0100 SUB, 0101 AND, 0110 OR, 0111 XOR: Rx<=Rx op Ry
  - 1000 NOT Rx<=~Rx
  - all others illegal
- Opcode, Rx, Ry, IMM and an illegal flag are latched on acceptance.
- All outputs except IREADY are functions of state and the latched fields only. There is no combinational path from INSTR or IVALID to any output.
- States:
  - IDLE: IREADY=1. On transfer: LOADI goes to IMMW; NOP or illegal goes to EXEC; all others go to READ.
  - IMMW: IREADY=1. On transfer the word is latched into IMM, then go to LDW. Without a transfer, stay.
  - LDW: WE=1, WA=Rx, RFSEL=1, DONE=1; then go to IDLE.
  - READ: RAA=Rx, RBA=Ry. RAE=1 except for MOV; RBE=1 except for NOT. Then go to EXEC.
  - EXEC: ALUOP driven from the opcode, RFSEL=0, DONE=1. WE=1 and WA=Rx for MOV/ALU ops. WE=0 for NOP and illegal opcodes, and ILLEGAL=1 for illegal. Then go to IDLE.
- Outside their asserting states: RAE, RBE, WE, DONE, ILLEGAL, RFSEL = 0 and ALUOP = 000. RAA, RBA and WA hold the latched fields.
- The ALU is combinational downstream, so the EXEC write captures op(A,B) in the same cycle the operands are valid.

## Timing
- Reset:
  - State goes to IDLE immediately.
  - All latched fields, IMM, and every output are 0.
  - IREADY is forced to 0 while reset is high and rises in the first cycle after deassertion.
- Register/ALU instruction, with acceptance at edge 0:
  - READ in cycle 1, with A/B registered at edge 1.
  - EXEC in cycle 2, with the write at edge 2.
  - IREADY high again in cycle 3.
  - Throughput: one instruction per 3 cycles.
- LOADI: opcode accept, IMMW (unbounded wait for IVALID), LDW. That is 3 cycles minimum.
- NOP or illegal: 2 cycles, acceptance then EXEC.
- IVALID low in IDLE or IMMW: hold state, no side effects.
- IVALID high while IREADY=0: the word is not consumed and must be held by the source.
- Reset asserted in any state, including mid-LOADI: the operation is abandoned, no partial write occurs, and the next word after reset is decoded as an opcode.
- Rx == Ry (e.g. ADD R1,R1): legal, and both ports read the same register.

## Configuration
- CONTROL_UNIT_HALT_EN defined:
  - Opcode 1111 is HALT. On acceptance, DONE pulses in the following cycle, then the controller enters state HALT.
  - In HALT, IREADY=0 and all enables are 0 until reset.
- CONTROL_UNIT_HALT_EN undefined: 1111 is illegal, and the HALT state is not built.

## Test plan
- Reset, then LOADI R2 (0x060) followed by word 0x155 → LDW cycle shows WE=1, WA=2, RFSEL=1, IMM=0x155, DONE=1; IREADY high the next cycle.
- ADD R1,R2 (0x0D8) accepted at edge 0 → cycle 1: RAE=RBE=1, RAA=1, RBA=2; cycle 2: ALUOP=001, WE=1, WA=1, DONE=1; cycle 3: IREADY=1.
- IVALID held high with a stream of three XOR words (0x1D8) → IREADY high exactly every third cycle and three DONE pulses; no word is skipped or duplicated.
- Illegal opcode 0x2C0 → next cycle DONE=1 and ILLEGAL=1 with WE=0; IREADY=1 the cycle after.
- Reset asserted during READ of SUB R3,R0 (0x130) → RAE, RBE, WE and IREADY go to 0 immediately with no write; after release, 0x060 is decoded as LOADI.
- With CONTROL_UNIT_HALT_EN: HALT 0x3C0 → one DONE pulse, then IREADY stays 0 for 10+ cycles despite IVALID=1; without the macro, 0x3C0 → ILLEGAL=1.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle sequencer feeding the 4-entry register file and its combinational ALU.
// Define CONTROL_UNIT_HALT_EN to build the HALT opcode (1111) and its terminal state.
module control_unit #(
    parameter int REGISTER_LEN = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [REGISTER_LEN-1:0] INSTR,
    input  logic                    IVALID,
    output logic                    IREADY,
    output logic                    RAE,
    output logic [1:0]              RAA,
    output logic                    RBE,
    output logic [1:0]              RBA,
    output logic                    WE,
    output logic [1:0]              WA,
    output logic [2:0]              ALUOP,
    output logic                    RFSEL,
    output logic [REGISTER_LEN-1:0] IMM,
    output logic                    DONE,
    output logic                    ILLEGAL
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LOADI = 4'h1,
        OP_MOV   = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_NOT   = 4'h8,
        OP_HALT  = 4'hF
    } opcode_t;

`ifdef CONTROL_UNIT_HALT_EN
    typedef enum logic [2:0] {S_IDLE, S_IMMW, S_LDW, S_READ, S_EXEC, S_HALT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_IMMW, S_LDW, S_READ, S_EXEC} state_t;
`endif

    state_t                  state, state_n;
    opcode_t                 op_q, dec_op;
    logic [1:0]              rx_q, ry_q;
    logic [REGISTER_LEN-1:0] imm_q;
    logic                    ill_q, dec_ill, dec_halt, xfer;

    always_comb begin
        dec_op   = opcode_t'(INSTR[9:6]);
        dec_halt = 1'b0;
        dec_ill  = (INSTR[9:6] > 4'h8);
`ifdef CONTROL_UNIT_HALT_EN
        if (INSTR[9:6] == 4'hF) begin
            dec_halt = 1'b1;
            dec_ill  = 1'b0;
        end
`endif
    end

    // Reset gates IREADY combinationally so the source never sees a transfer while held.
    always_comb begin
        IREADY = 1'b0;
        if (!reset && (state == S_IDLE || state == S_IMMW))
            IREADY = 1'b1;
    end

    assign xfer = IVALID && IREADY;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= OP_NOP;
            rx_q  <= '0;
            ry_q  <= '0;
            ill_q <= 1'b0;
            imm_q <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && xfer) begin
                op_q  <= dec_op;
                rx_q  <= INSTR[5:4];
                ry_q  <= INSTR[3:2];
                ill_q <= dec_ill;
            end
            if (state == S_IMMW && xfer)
                imm_q <= INSTR;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    if (dec_ill || dec_halt || dec_op == OP_NOP)
                        state_n = S_EXEC;
                    else if (dec_op == OP_LOADI)
                        state_n = S_IMMW;
                    else
                        state_n = S_READ;
                end
            end
            S_IMMW: if (xfer) state_n = S_LDW;
            S_LDW:  state_n = S_IDLE;
            S_READ: state_n = S_EXEC;
            S_EXEC: begin
                state_n = S_IDLE;
`ifdef CONTROL_UNIT_HALT_EN
                if (!ill_q && op_q == OP_HALT)
                    state_n = S_HALT;
`endif
            end
`ifdef CONTROL_UNIT_HALT_EN
            S_HALT: state_n = S_HALT;
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        RAE     = 1'b0;
        RBE     = 1'b0;
        WE      = 1'b0;
        DONE    = 1'b0;
        ILLEGAL = 1'b0;
        RFSEL   = 1'b0;
        ALUOP   = 3'b000;
        RAA     = rx_q;
        RBA     = ry_q;
        WA      = rx_q;
        IMM     = imm_q;
        case (state)
            S_LDW: begin
                WE    = 1'b1;
                RFSEL = 1'b1;
                DONE  = 1'b1;
            end
            S_READ: begin
                RAE = (op_q != OP_MOV);
                RBE = (op_q != OP_NOT);
            end
            S_EXEC: begin
                DONE = 1'b1;
                if (ill_q) begin
                    ILLEGAL = 1'b1;
                end else begin
                    case (op_q)
                        OP_MOV:  begin WE = 1'b1; ALUOP = 3'b000; end
                        OP_ADD:  begin WE = 1'b1; ALUOP = 3'b001; end
                        OP_SUB:  begin WE = 1'b1; ALUOP = 3'b010; end
                        OP_AND:  begin WE = 1'b1; ALUOP = 3'b011; end
                        OP_OR:   begin WE = 1'b1; ALUOP = 3'b100; end
                        OP_XOR:  begin WE = 1'b1; ALUOP = 3'b101; end
                        OP_NOT:  begin WE = 1'b1; ALUOP = 3'b110; end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; honours CONTROL_UNIT_HALT_EN for the 1111 case.
module tb_control_unit;

    logic       clock;
    logic       reset;
    logic [9:0] INSTR;
    logic       IVALID;
    logic       IREADY, RAE, RBE, WE, RFSEL, DONE, ILLEGAL;
    logic [1:0] RAA, RBA, WA;
    logic [2:0] ALUOP;
    logic [9:0] IMM;

    int checks   = 0;
    int failures = 0;

    control_unit #(.REGISTER_LEN(10)) dut (
        .clock(clock), .reset(reset), .INSTR(INSTR), .IVALID(IVALID), .IREADY(IREADY),
        .RAE(RAE), .RAA(RAA), .RBE(RBE), .RBA(RBA), .WE(WE), .WA(WA),
        .ALUOP(ALUOP), .RFSEL(RFSEL), .IMM(IMM), .DONE(DONE), .ILLEGAL(ILLEGAL)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ctl(input string tag, input int rdy, input int rae, input int rbe,
                              input int we, input int rfsel, input int done, input int ill,
                              input int aluop);
        check({tag, ".IREADY"},  32'(IREADY),  rdy);
        check({tag, ".RAE"},     32'(RAE),     rae);
        check({tag, ".RBE"},     32'(RBE),     rbe);
        check({tag, ".WE"},      32'(WE),      we);
        check({tag, ".RFSEL"},   32'(RFSEL),   rfsel);
        check({tag, ".DONE"},    32'(DONE),    done);
        check({tag, ".ILLEGAL"}, 32'(ILLEGAL), ill);
        check({tag, ".ALUOP"},   32'(ALUOP),   aluop);
    endtask

    // Register/ALU instruction from IDLE: accept, READ, EXEC, back to IDLE.
    task automatic run_reg(input string tag, input logic [9:0] word, input int rae, input int rbe,
                           input int raa, input int rba, input int aluop, input int wa);
        INSTR  = word;
        IVALID = 1'b1;
        tick();
        IVALID = 1'b0;
        expect_ctl({tag, ".read"}, 0, rae, rbe, 0, 0, 0, 0, 0);
        check({tag, ".read.RAA"}, 32'(RAA), raa);
        check({tag, ".read.RBA"}, 32'(RBA), rba);
        tick();
        expect_ctl({tag, ".exec"}, 0, 0, 0, 1, 0, 1, 0, aluop);
        check({tag, ".exec.WA"}, 32'(WA), wa);
        tick();
        expect_ctl({tag, ".idle"}, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // NOP / illegal: accept, EXEC with no write, back to IDLE.
    task automatic run_short(input string tag, input logic [9:0] word, input int ill);
        INSTR  = word;
        IVALID = 1'b1;
        tick();
        IVALID = 1'b0;
        expect_ctl({tag, ".exec"}, 0, 0, 0, 0, 0, 1, ill, 0);
        tick();
        expect_ctl({tag, ".idle"}, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [9:0] words [3];
    int         wrx   [3];
    int         wry   [3];
    int         dones;

    initial begin
        reset  = 1'b1;
        IVALID = 1'b0;
        INSTR  = '0;
        #1;
        expect_ctl("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset.RAA", 32'(RAA), 0);
        check("reset.RBA", 32'(RBA), 0);
        check("reset.WA",  32'(WA),  0);
        check("reset.IMM", 32'(IMM), 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset.release.IREADY", 32'(IREADY), 1);

        // LOADI R2 with an idle gap before the immediate arrives
        INSTR  = 10'h060;
        IVALID = 1'b1;
        tick();
        IVALID = 1'b0;
        INSTR  = 10'h3FF;
        expect_ctl("loadi.immw", 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_ctl("loadi.immw_hold", 1, 0, 0, 0, 0, 0, 0, 0);
        check("loadi.immw_hold.IMM", 32'(IMM), 0);
        INSTR  = 10'h155;
        IVALID = 1'b1;
        tick();
        IVALID = 1'b0;
        expect_ctl("loadi.ldw", 0, 0, 0, 1, 1, 1, 0, 0);
        check("loadi.ldw.WA",  32'(WA),  2);
        check("loadi.ldw.IMM", 32'(IMM), 32'h155);
        tick();
        expect_ctl("loadi.idle", 1, 0, 0, 0, 0, 0, 0, 0);

        run_reg("add_r1_r2", 10'h0D8, 1, 1, 1, 2, 1, 1);
        run_reg("add_r1_r1", 10'h0D4, 1, 1, 1, 1, 1, 1);
        run_reg("mov_r0_r3", 10'h08C, 0, 1, 0, 3, 0, 0);
        run_reg("not_r2",    10'h220, 1, 0, 2, 0, 6, 2);
        run_reg("or_r3_r1",  10'h1B4, 1, 1, 3, 1, 4, 3);
        run_short("nop",     10'h000, 0);
        run_short("illegal", 10'h2C0, 1);

        // Back-to-back XOR stream with IVALID held high
        words[0] = 10'h1D8; wrx[0] = 1; wry[0] = 2;
        words[1] = 10'h1E4; wrx[1] = 2; wry[1] = 1;
        words[2] = 10'h1CC; wrx[2] = 0; wry[2] = 3;
        dones  = 0;
        INSTR  = words[0];
        IVALID = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("stream.c%0d.IREADY", k), 32'(IREADY), (k % 3 == 0) ? 1 : 0);
            check($sformatf("stream.c%0d.DONE", k),   32'(DONE),   (k % 3 == 2) ? 1 : 0);
            if (DONE) dones++;
            if (k % 3 == 1) begin
                check($sformatf("stream.c%0d.RAA", k), 32'(RAA), wrx[k / 3]);
                check($sformatf("stream.c%0d.RBA", k), 32'(RBA), wry[k / 3]);
                if (k / 3 < 2) INSTR = words[k / 3 + 1];
                else IVALID = 1'b0;
            end
            if (k % 3 == 2) begin
                check($sformatf("stream.c%0d.WA", k),    32'(WA),    wrx[k / 3]);
                check($sformatf("stream.c%0d.ALUOP", k), 32'(ALUOP), 5);
                check($sformatf("stream.c%0d.WE", k),    32'(WE),    1);
            end
            tick();
        end
        check("stream.done_count", 32'(dones), 3);
        expect_ctl("stream.idle", 1, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-READ of SUB R3,R0, then LOADI must decode cleanly
        INSTR  = 10'h130;
        IVALID = 1'b1;
        tick();
        IVALID = 1'b0;
        expect_ctl("sub.read", 0, 1, 1, 0, 0, 0, 0, 0);
        check("sub.read.RAA", 32'(RAA), 3);
        #2;
        reset = 1'b1;
        #1;
        expect_ctl("sub.reset", 0, 0, 0, 0, 0, 0, 0, 0);
        check("sub.reset.RAA", 32'(RAA), 0);
        tick();
        expect_ctl("sub.reset_hold", 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("sub.release.IREADY", 32'(IREADY), 1);
        INSTR  = 10'h060;
        IVALID = 1'b1;
        tick();
        expect_ctl("post_reset.immw", 1, 0, 0, 0, 0, 0, 0, 0);
        INSTR = 10'h0AA;
        tick();
        IVALID = 1'b0;
        expect_ctl("post_reset.ldw", 0, 0, 0, 1, 1, 1, 0, 0);
        check("post_reset.ldw.WA",  32'(WA),  2);
        check("post_reset.ldw.IMM", 32'(IMM), 32'h0AA);
        tick();
        expect_ctl("post_reset.idle", 1, 0, 0, 0, 0, 0, 0, 0);

`ifdef CONTROL_UNIT_HALT_EN
        INSTR  = 10'h3C0;
        IVALID = 1'b1;
        tick();
        expect_ctl("halt.exec", 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_ctl($sformatf("halt.c%0d", i), 0, 0, 0, 0, 0, 0, 0, 0);
        end
        IVALID = 1'b0;
`else
        run_short("op1111", 10'h3C0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
